// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with per-register busy scoreboard and operand hazard detection.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_scoreboard #(
    parameter int REG_WIDTH = 32,
    parameter int REG_COUNT = 32,
    parameter int NUM_READ_PORTS = 2,
    localparam int AW = $clog2(REG_COUNT)
) (
    input  logic                             CLK,
    input  logic                             Reset_n,
    input  logic [NUM_READ_PORTS*AW-1:0]        ReadAddr,
    input  logic [NUM_READ_PORTS-1:0]           ReadEn,
    output logic [NUM_READ_PORTS*REG_WIDTH-1:0] ReadData,
    input  logic                             IssueValid,
    input  logic [AW-1:0]                    IssueRd,
    input  logic                             RegWrite,
    input  logic [AW-1:0]                    WriteAddress,
    input  logic [REG_WIDTH-1:0]             WriteData,
    input  logic                             Flush,
    output logic [NUM_READ_PORTS-1:0]           Hazard,
    output logic                             Stall
);
    logic [REG_WIDTH-1:0] regs [REG_COUNT];
    logic [REG_COUNT-1:0] busy, busy_next;
    logic wr;

    assign wr = RegWrite && (WriteAddress != '0);

    // Issue is applied after writeback so a same-register pair leaves the new producer busy
    always_comb begin
        busy_next = busy;
        if (wr) busy_next[WriteAddress] = 1'b0;
        if (IssueValid && IssueRd != '0) busy_next[IssueRd] = 1'b1;
        if (Flush) busy_next = '0;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            if (wr) regs[WriteAddress] <= WriteData;
            busy <= busy_next;
        end
    end

    for (genvar g = 0; g < NUM_READ_PORTS; g++) begin : g_port
        logic [AW-1:0] ra;
        logic hit;
        assign ra = ReadAddr[g*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        assign hit = wr && (WriteAddress == ra);
`else
        assign hit = 1'b0;
`endif
        assign ReadData[g*REG_WIDTH +: REG_WIDTH] = hit ? WriteData :
                                                    (ra == '0) ? {REG_WIDTH{1'b0}} : regs[ra];
        assign Hazard[g] = ReadEn[g] & busy[ra] & ~hit;
    end

    assign Stall = |Hazard;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed vector table plus randomized run against a behavioural model.
module tb_regfile_scoreboard;
    logic        CLK = 1'b0;
    logic        Reset_n;
    logic [9:0]  ReadAddr;
    logic [1:0]  ReadEn;
    logic [63:0] ReadData;
    logic        IssueValid;
    logic [4:0]  IssueRd;
    logic        RegWrite;
    logic [4:0]  WriteAddress;
    logic [31:0] WriteData;
    logic        Flush;
    logic [1:0]  Hazard;
    logic        Stall;

    regfile_scoreboard dut (
        .CLK(CLK), .Reset_n(Reset_n), .ReadAddr(ReadAddr), .ReadEn(ReadEn),
        .ReadData(ReadData), .IssueValid(IssueValid), .IssueRd(IssueRd),
        .RegWrite(RegWrite), .WriteAddress(WriteAddress), .WriteData(WriteData),
        .Flush(Flush), .Hazard(Hazard), .Stall(Stall)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst_n;
        logic [1:0]  ren;
        logic [4:0]  ra0, ra1;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        iv;
        logic [4:0]  ird;
        logic        fl;
        logic        chk;
        logic [31:0] e_d0, e_d1;
        logic [1:0]  e_hz;
        logic        e_st;
    } vec_t;

    vec_t vecs[$];
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] mregs [32];
    logic        mbusy [32];
    bit bypass;

    function automatic vec_t mk(logic rst_n, logic [1:0] ren, logic [4:0] ra0, logic [4:0] ra1,
                                logic we, logic [4:0] wa, logic [31:0] wd, logic iv, logic [4:0] ird,
                                logic fl, logic chk, logic [31:0] e_d0, logic [31:0] e_d1,
                                logic [1:0] e_hz, logic e_st);
        vec_t v;
        v.rst_n = rst_n; v.ren = ren; v.ra0 = ra0; v.ra1 = ra1; v.we = we; v.wa = wa; v.wd = wd;
        v.iv = iv; v.ird = ird; v.fl = fl; v.chk = chk;
        v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_hz = e_hz; v.e_st = e_st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Register file semantics as stated: writes commit, busy set on issue, flush/reset clear
    task automatic model_edge();
        if (!Reset_n) begin
            for (int i = 0; i < 32; i++) begin
                mregs[i] = '0;
                mbusy[i] = 1'b0;
            end
        end else begin
            if (RegWrite && WriteAddress != 0) mregs[WriteAddress] = WriteData;
            if (Flush) begin
                for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
            end else begin
                if (RegWrite && WriteAddress != 0) mbusy[WriteAddress] = 1'b0;
                if (IssueValid && IssueRd != 0) mbusy[IssueRd] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic model_check(input int cyc);
        logic [1:0] exp_hz;
        for (int p = 0; p < 2; p++) begin
            logic [4:0] a;
            logic fwd;
            logic [31:0] d;
            a = ReadAddr[p*5 +: 5];
            fwd = bypass && RegWrite && WriteAddress != 0 && WriteAddress == a;
            d = fwd ? WriteData : (a == 0 ? 32'h0 : mregs[a]);
            exp_hz[p] = ReadEn[p] && a != 0 && mbusy[a] && !fwd;
            chk($sformatf("rnd%0d data%0d", cyc, p), ReadData[p*32 +: 32], d);
            chk($sformatf("rnd%0d hazard%0d", cyc, p), {31'h0, Hazard[p]}, {31'h0, exp_hz[p]});
        end
        chk($sformatf("rnd%0d stall", cyc), {31'h0, Stall}, {31'h0, |exp_hz});
    endtask

    function automatic logic [4:0] raddr();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    initial begin
        logic [31:0] b_d;
        logic [1:0]  b_hz;
        logic        b_st;
`ifdef REGFILE_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        for (int i = 0; i < 32; i++) begin
            mregs[i] = '0;
            mbusy[i] = 1'b0;
        end
        Reset_n = 0; ReadAddr = '0; ReadEn = '0; IssueValid = 0; IssueRd = '0;
        RegWrite = 0; WriteAddress = '0; WriteData = '0; Flush = 0;

        //        rst ren ra0 ra1 we wa  wd            iv ird fl chk e_d0          e_d1          hz     st
        vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 32'h0,        0, 0, 0, 1, 32'h0,        32'h0,        2'b00, 0));
        vecs.push_back(mk(1, 2'b00, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0,        32'h0,        2'b00, 0));
        vecs.push_back(mk(0, 2'b01, 5, 0, 1, 6, 32'h11111111, 1, 8, 0, 1, 32'hDEADBEEF, 32'h0,        2'b00, 0));
        vecs.push_back(mk(1, 2'b11, 5, 6, 0, 0, 32'h0,        0, 0, 0, 1, 32'h0,        32'h0,        2'b00, 0));
        vecs.push_back(mk(1, 2'b11, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 1, 32'h0,        32'h0,        2'b00, 0));
        vecs.push_back(mk(1, 2'b11, 0, 0, 0, 0, 32'h0,        0, 0, 0, 1, 32'h0,        32'h0,        2'b00, 0));
        vecs.push_back(mk(1, 2'b00, 0, 0, 0, 0, 32'h0,        1, 7, 0, 0, 32'h0,        32'h0,        2'b00, 0));
        vecs.push_back(mk(1, 2'b10, 0, 7, 0, 0, 32'h0,        0, 0, 0, 1, 32'h0,        32'h0,        2'b10, 1));
        b_d = bypass ? 32'h1234 : 32'h0; b_hz = bypass ? 2'b00 : 2'b10; b_st = !bypass;
        vecs.push_back(mk(1, 2'b10, 0, 7, 1, 7, 32'h1234,     0, 0, 0, 1, 32'h0,        b_d,          b_hz,  b_st));
        vecs.push_back(mk(1, 2'b10, 0, 7, 0, 0, 32'h0,        0, 0, 0, 1, 32'h0,        32'h1234,     2'b00, 0));
        vecs.push_back(mk(1, 2'b00, 0, 0, 0, 0, 32'h0,        1, 3, 0, 0, 32'h0,        32'h0,        2'b00, 0));
        b_d = bypass ? 32'hAA : 32'h0; b_hz = bypass ? 2'b00 : 2'b11;
        vecs.push_back(mk(1, 2'b11, 3, 3, 1, 3, 32'hAA,       0, 0, 0, 1, b_d,          b_d,          b_hz,  b_st));
        vecs.push_back(mk(1, 2'b01, 3, 0, 0, 0, 32'h0,        0, 0, 0, 1, 32'hAA,       32'h0,        2'b00, 0));
        vecs.push_back(mk(1, 2'b00, 0, 0, 1, 9, 32'h55,       1, 9, 0, 0, 32'h0,        32'h0,        2'b00, 0));
        vecs.push_back(mk(1, 2'b11, 9, 9, 1, 4, 32'h44,       0, 0, 0, 1, 32'h55,       32'h55,       2'b11, 1));
        vecs.push_back(mk(1, 2'b00, 0, 0, 1, 6, 32'h66,       1, 4, 0, 0, 32'h0,        32'h0,        2'b00, 0));
        vecs.push_back(mk(1, 2'b00, 0, 0, 0, 0, 32'h0,        1, 6, 0, 0, 32'h0,        32'h0,        2'b00, 0));
        vecs.push_back(mk(1, 2'b11, 4, 6, 1, 9, 32'h99,       1, 10, 1, 1, 32'h44,      32'h66,       2'b11, 1));
        vecs.push_back(mk(1, 2'b11, 4, 6, 0, 0, 32'h0,        0, 0, 0, 1, 32'h44,       32'h66,       2'b00, 0));
        vecs.push_back(mk(1, 2'b11, 10, 9, 0, 0, 32'h0,       0, 0, 0, 1, 32'h0,        32'h99,       2'b00, 0));

        foreach (vecs[k]) begin
            Reset_n = vecs[k].rst_n; ReadEn = vecs[k].ren; ReadAddr = {vecs[k].ra1, vecs[k].ra0};
            RegWrite = vecs[k].we; WriteAddress = vecs[k].wa; WriteData = vecs[k].wd;
            IssueValid = vecs[k].iv; IssueRd = vecs[k].ird; Flush = vecs[k].fl;
            @(negedge CLK);
            if (vecs[k].chk) begin
                chk($sformatf("vec%0d data0", k), ReadData[31:0], vecs[k].e_d0);
                chk($sformatf("vec%0d data1", k), ReadData[63:32], vecs[k].e_d1);
                chk($sformatf("vec%0d hazard", k), {30'h0, Hazard}, {30'h0, vecs[k].e_hz});
                chk($sformatf("vec%0d stall", k), {31'h0, Stall}, {31'h0, vecs[k].e_st});
            end
            tick();
        end

        for (int c = 0; c < 3000; c++) begin
            Reset_n = $urandom_range(0, 99) != 0;
            ReadEn = 2'($urandom_range(0, 3));
            ReadAddr = {raddr(), raddr()};
            RegWrite = $urandom_range(0, 1) == 1;
            WriteAddress = raddr();
            WriteData = $urandom;
            IssueValid = $urandom_range(0, 2) != 0;
            IssueRd = raddr();
            Flush = $urandom_range(0, 15) == 0;
            @(negedge CLK);
            model_check(c);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL take parameter REG_WIDTH, default 32, data width of each register.
REQ-002 SHALL take parameter REG_COUNT, default 32, number of architectural registers (power of two, >=2).
REQ-003 SHALL take parameter NUM_READ_PORTS, default 2, number of independent read ports (1..4).
REQ-004 SHALL derive localparam AW = $clog2(REG_COUNT) for all register addresses.
REQ-005 CLK  input  1  single clock; all state updates on rising edge.
REQ-006 Reset_n  input  1  reset; synchronous, active-low.
REQ-007 ReadAddr  input  NUM_READ_PORTS*AW  packed read addresses; port i in bits [i*AW +: AW].
REQ-008 ReadEn  input  NUM_READ_PORTS  port i requests a source operand this cycle.
REQ-009 ReadData  output  NUM_READ_PORTS*REG_WIDTH  packed read data, port i in [i*REG_WIDTH +: REG_WIDTH].
REQ-010 IssueValid  input  1  an instruction with a destination register issues this cycle.
REQ-011 IssueRd  input  AW  destination register of the issuing instruction.
REQ-012 RegWrite  input  1  writeback strobe.
REQ-013 WriteAddress  input  AW  writeback destination.
REQ-014 WriteData  input  REG_WIDTH  writeback data.
REQ-015 Flush  input  1  discard all pending (in-flight) destinations.
REQ-016 Hazard  output  NUM_READ_PORTS  port i operand not yet available.
REQ-017 Stall  output  1  OR of Hazard[i] over all ports.

Function
REQ-018 ReadData[i] SHALL be combinational: Registers[ReadAddr[i]]; address 0 always reads 0.
REQ-019 On a rising edge with RegWrite=1 and WriteAddress!=0, Registers[WriteAddress] SHALL take WriteData; writes to address 0 SHALL be discarded.
REQ-020 Each register 1..REG_COUNT-1 SHALL carry a Busy bit; Busy[0] SHALL be constant 0.
REQ-021 IssueValid=1 with IssueRd!=0 SHALL set Busy[IssueRd] at the next edge.
REQ-022 RegWrite=1 with WriteAddress!=0 SHALL clear Busy[WriteAddress] at the next edge.
REQ-023 Issue and writeback to the same register in the same cycle: Busy SHALL end set (new producer wins); data still written.
REQ-024 Flush=1 SHALL clear all Busy bits at the next edge; register contents unaffected; a same-cycle writeback still commits data; a same-cycle issue is discarded.
REQ-025 Hazard[i] SHALL be combinational: ReadEn[i] & Busy[ReadAddr[i]] & ~bypass_hit[i]; Hazard[i]=0 whenever ReadEn[i]=0 or ReadAddr[i]=0.
REQ-026 Without bypass, bypass_hit[i] SHALL be 0; a read of a register being written this cycle returns old data and Hazard stays asserted.
REQ-027 Multiple read ports addressing the same register SHALL return identical data and Hazard values.

Reset
REQ-028 While Reset_n=0 at a rising edge, all registers SHALL become 0 and all Busy bits 0; reset SHALL override RegWrite, IssueValid and Flush.
REQ-029 After reset, ReadData SHALL be 0, Hazard 0 and Stall 0 on all ports until the first write or issue.
REQ-030 Reset asserted mid-operation SHALL discard any same-cycle write; nothing SHALL commit on that edge.

Configuration
REQ-031 Macro REGFILE_BYPASS_EN defined: when RegWrite=1, WriteAddress!=0 and WriteAddress==ReadAddr[i], ReadData[i] SHALL equal WriteData combinationally and bypass_hit[i]=1.
REQ-032 Macro REGFILE_BYPASS_EN undefined: no forwarding path is present; REQ-026 applies.

Verification
REQ-033 Reset_n=0 for one edge after writing x5=0xDEAD_BEEF -> read x5 returns 0x0000_0000, Stall=0.
REQ-034 RegWrite, WriteAddress=0, WriteData=0xFFFF_FFFF; then IssueRd=0 -> read x0 returns 0, Hazard=0.
REQ-035 Issue x7; next cycle ReadEn[1]=1, ReadAddr[1]=7 -> Hazard[1]=1, Stall=1; writeback x7=0x1234 -> next cycle Hazard=0, ReadData[1]=0x1234.
REQ-036 Writeback x3=0xAA and read x3 in the same cycle -> with REGFILE_BYPASS_EN: ReadData=0xAA, Hazard=0; without: old value, Hazard=1 if x3 was busy.
REQ-037 Same-cycle issue x9 and writeback x9=0x55 -> x9 holds 0x55, Busy[9]=1; read x9 next cycle gives Hazard=1.
REQ-038 Issue x4, x6; assert Flush -> next cycle reads of x4, x6 show Hazard=0, contents unchanged.
